sm_from_tc_serial: RTL

- Bit-serial decoder from two's-complement to sign-magnitude for the datapath ALU.
- It is the reverse direction of the combinational two's-complement negate stage.
- A signed operand is accepted on a ready/start handshake and returned as a sign bit plus an unsigned magnitude.
- Negative operands are processed one bit per cycle using the copy-through-first-1-then-invert rule. The block is used by multi-cycle MUL/DIV sequencing, which works on magnitudes.

---
 rtl/sm_from_tc_serial.sv | 101 ++++++++++
 1 files changed

// File: rtl/sm_from_tc_serial.sv
// Bit-serial two's-complement to sign-magnitude decoder.
// Negative operands are negated LSB-first: copy up to and including the first 1, then invert.
module sm_from_tc_serial #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] Ra,
  output logic             ready,
  output logic             done,
  output logic             sign,
  output logic [WIDTH-1:0] Rz,
  output logic             min_neg
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             found_q, found_d;
  logic [WIDTH-1:0] rz_q, rz_d;
  logic             sign_q, sign_d;
  logic             min_neg_q, min_neg_d;

  logic             out_bit;
  logic [WIDTH-1:0] shifted;

  assign out_bit = found_q ? ~sr_q[0] : sr_q[0];
  assign shifted = {out_bit, sr_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    found_d   = found_q;
    rz_d      = rz_q;
    sign_d    = sign_q;
    min_neg_d = min_neg_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = Ra;
          cnt_d   = '0;
          found_d = 1'b0;
          // Non-negative operands already are their own magnitude.
          if (!Ra[WIDTH-1]) begin
            rz_d      = Ra;
            sign_d    = 1'b0;
            min_neg_d = 1'b0;
            state_d   = DONE;
          end else begin
            state_d   = SHIFT;
          end
        end
      end
      SHIFT: begin
        sr_d    = shifted;
        found_d = found_q | sr_q[0];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          rz_d      = shifted;
          sign_d    = 1'b1;
          min_neg_d = (shifted == MIN_NEG);
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      found_q   <= 1'b0;
      rz_q      <= '0;
      sign_q    <= 1'b0;
      min_neg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      found_q   <= found_d;
      rz_q      <= rz_d;
      sign_q    <= sign_d;
      min_neg_q <= min_neg_d;
    end
  end

  assign ready   = (state_q == IDLE);
  assign done    = (state_q == DONE);
  assign Rz      = rz_q;
  assign sign    = sign_q;
  assign min_neg = min_neg_q;
endmodule
